// File: rtl/instruction_loader_pkg.sv
// Shared constants, FSM state encoding and width helper for the instruction loader.
package instruction_loader_pkg;

  localparam int unsigned BYTE_SIZE = 8;
  localparam logic [31:0] HALT_INSTRUCTION_DEFAULT = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RECEIVE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4,
    ST_ERROR   = 3'd5
  } state_e;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int unsigned min_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory side outputs of the instruction loader.
interface instruction_loader_if
  import instruction_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE_IN_WORDS = 64,
  parameter int unsigned WORD_W            = 32
);

  localparam int unsigned CNT_W = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic                 i_start;
  logic                 i_byte_valid;
  logic [BYTE_SIZE-1:0] i_byte;
  logic                 o_clear_mem;
  logic                 o_instruction_write;
  logic [WORD_W-1:0]    o_instruction;
  logic [CNT_W-1:0]     o_word_count;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_error;

  modport master (
    output i_start, i_byte_valid, i_byte,
    input  o_clear_mem, o_instruction_write, o_instruction, o_word_count,
           o_busy, o_done, o_error
  );

  modport slave (
    input  i_start, i_byte_valid, i_byte,
    output o_clear_mem, o_instruction_write, o_instruction, o_word_count,
           o_busy, o_done, o_error
  );

endinterface

// File: rtl/instruction_loader_byte_packer.sv
// MSB-first byte shift register with a byte counter; flags the byte that completes a word.
module instruction_loader_byte_packer
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WORD_SIZE_IN_BYTES = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    clear_i,
  input  logic                                    shift_i,
  input  logic [BYTE_SIZE-1:0]                    byte_i,
  output logic [WORD_SIZE_IN_BYTES*BYTE_SIZE-1:0] word_next_c_o,
  output logic                                    word_ready_c_o
);

  localparam int unsigned WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int unsigned CNT_W  = min_width(WORD_SIZE_IN_BYTES);

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign word_next_c_o  = {word_q[WORD_W-BYTE_SIZE-1:0], byte_i};
  assign word_ready_c_o = shift_i && (cnt_q == CNT_W'(WORD_SIZE_IN_BYTES - 1));

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = word_next_c_o;
      cnt_d  = word_ready_c_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// Packs a debug-unit byte stream into instruction words and writes them to instruction memory,
// clearing the memory first and stopping on the HALT word or when the memory is full.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WORD_SIZE_IN_BYTES = 4,
  parameter int unsigned MEM_SIZE_IN_WORDS  = 64,
  parameter logic [31:0] HALT_INSTRUCTION   = HALT_INSTRUCTION_DEFAULT
) (
  input logic           i_clk,
  input logic           i_reset,
  instruction_loader_if.slave bus
);

  localparam int unsigned WORD_W = WORD_SIZE_IN_BYTES * BYTE_SIZE;
  localparam int unsigned CW     = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [WORD_W-1:0] HALT_W = WORD_W'(HALT_INSTRUCTION);

  state_e            state_q, state_d;
  logic              clear_mem_q, clear_mem_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              pk_clear;
  logic              pk_shift;
  logic              pk_ready;
  logic [WORD_W-1:0] pk_word;

  logic              write_continues;

  // A WRITE that returns to RECEIVE already accepts the first byte of the next word.
  assign write_continues = (instr_q != HALT_W) && (cnt_q != CW'(MEM_SIZE_IN_WORDS));
  assign pk_clear = (state_q == ST_IDLE) && bus.i_start;
  assign pk_shift = bus.i_byte_valid &&
                    ((state_q == ST_RECEIVE) || ((state_q == ST_WRITE) && write_continues));

  instruction_loader_byte_packer #(
    .WORD_SIZE_IN_BYTES(WORD_SIZE_IN_BYTES)
  ) u_packer (
    .clk_i         (i_clk),
    .rst_i         (i_reset),
    .clear_i       (pk_clear),
    .shift_i       (pk_shift),
    .byte_i        (bus.i_byte),
    .word_next_c_o (pk_word),
    .word_ready_c_o(pk_ready)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_CLEAR;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_CLEAR:   state_d = ST_RECEIVE;
      ST_RECEIVE: begin
        if (pk_ready) begin
          state_d = ST_WRITE;
          instr_d = pk_word;
          cnt_d   = (cnt_q == CW'(MEM_SIZE_IN_WORDS)) ? cnt_q : cnt_q + CW'(1);
        end
      end
      ST_WRITE: begin
        if (instr_q == HALT_W)                         state_d = ST_DONE;
        else if (cnt_q == CW'(MEM_SIZE_IN_WORDS))      state_d = ST_ERROR;
        else                                           state_d = ST_RECEIVE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase

    clear_mem_d = (state_d == ST_CLEAR);
    wr_d        = (state_d == ST_WRITE);
    busy_d      = (state_d == ST_CLEAR) || (state_d == ST_RECEIVE) || (state_d == ST_WRITE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      clear_mem_q <= 1'b0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      instr_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      clear_mem_q <= clear_mem_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      instr_q     <= instr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.o_clear_mem         = clear_mem_q;
  assign bus.o_instruction_write = wr_q;
  assign bus.o_instruction       = instr_q;
  assign bus.o_word_count        = cnt_q;
  assign bus.o_busy              = busy_q;
  assign bus.o_done              = done_q;
  assign bus.o_error             = err_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Drives one random byte stream into a 64-word and a 4-word loader and checks both against a word-level model.
module tb_instruction_loader;

  localparam logic [31:0] HALT = 32'h0000_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       bv;
  logic [7:0] bt;

  always #5 clk = ~clk;

  instruction_loader_if #(.MEM_SIZE_IN_WORDS(64)) bus64 ();
  instruction_loader_if #(.MEM_SIZE_IN_WORDS(4))  bus4 ();

  assign bus64.i_start      = start;
  assign bus64.i_byte_valid = bv;
  assign bus64.i_byte       = bt;
  assign bus4.i_start       = start;
  assign bus4.i_byte_valid  = bv;
  assign bus4.i_byte        = bt;

  instruction_loader #(.MEM_SIZE_IN_WORDS(64)) dut64 (.i_clk(clk), .i_reset(rst), .bus(bus64));
  instruction_loader #(.MEM_SIZE_IN_WORDS(4))  dut4  (.i_clk(clk), .i_reset(rst), .bus(bus4));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          obs_n[2] = '{0, 0};
  int          clr_n[2] = '{0, 0};
  logic [31:0] obs_w[2][512];
  int          obs_c[2][512];
  int          obs_k[2][512];
  int          base_n[2];
  int          base_clr[2];
  logic [7:0]  q_b[$];
  int          q_e[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-strobe and clear-pulse monitor, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (bus64.o_instruction_write && obs_n[0] < 512) begin
      obs_w[0][obs_n[0]] <= bus64.o_instruction;
      obs_c[0][obs_n[0]] <= cyc;
      obs_k[0][obs_n[0]] <= 32'(bus64.o_word_count);
      obs_n[0]           <= obs_n[0] + 1;
    end
    if (bus4.o_instruction_write && obs_n[1] < 512) begin
      obs_w[1][obs_n[1]] <= bus4.o_instruction;
      obs_c[1][obs_n[1]] <= cyc;
      obs_k[1][obs_n[1]] <= 32'(bus4.o_word_count);
      obs_n[1]           <= obs_n[1] + 1;
    end
    if (bus64.o_clear_mem) clr_n[0] <= clr_n[0] + 1;
    if (bus4.o_clear_mem)  clr_n[1] <= clr_n[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // {clear_mem, write, busy, done, error}
  function automatic logic [31:0] flags(input int sel);
    if (sel == 0)
      return 32'({bus64.o_clear_mem, bus64.o_instruction_write, bus64.o_busy, bus64.o_done, bus64.o_error});
    return 32'({bus4.o_clear_mem, bus4.o_instruction_write, bus4.o_busy, bus4.o_done, bus4.o_error});
  endfunction

  function automatic logic [31:0] wcount(input int sel);
    return (sel == 0) ? 32'(bus64.o_word_count) : 32'(bus4.o_word_count);
  endfunction

  function automatic logic [31:0] instr(input int sel);
    return (sel == 0) ? bus64.o_instruction : bus4.o_instruction;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    for (int s = 0; s < 2; s++) begin
      base_n[s]   = obs_n[s];
      base_clr[s] = clr_n[s];
    end
    q_b.delete();
    q_e.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("start_flags%0d", s), flags(s), 32'b10100);
      check($sformatf("start_count%0d", s), wcount(s), 32'd0);
    end
    tick();
    for (int s = 0; s < 2; s++) check($sformatf("clear_once%0d", s), flags(s), 32'b00100);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int g = int'($urandom_range(32'(max_gap), 0));
    repeat (g) tick();
    bv = 1'b1;
    bt = b;
    q_b.push_back(b);
    q_e.push_back(cyc + 1);
    tick();
    bv = 1'b0;
    bt = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], max_gap);
  endtask

  // Reference: words in stream order up to and including HALT, or until the memory holds mem words.
  task automatic model_check(input int sel, input int mem);
    int          exp_n  = 0;
    int          halted = 0;
    int          idx;
    logic [31:0] w      = '0;
    for (int i = 0; i < q_b.size() / 4; i++) begin
      w   = {q_b[4*i], q_b[4*i+1], q_b[4*i+2], q_b[4*i+3]};
      idx = base_n[sel] + exp_n;
      exp_n++;
      if (idx < obs_n[sel]) begin
        check($sformatf("word%0d_%0d", sel, exp_n), obs_w[sel][idx], w);
        check($sformatf("latency%0d_%0d", sel, exp_n), 32'(obs_c[sel][idx]), 32'(q_e[4*i+3]));
        check($sformatf("wcount_at_wr%0d_%0d", sel, exp_n), 32'(obs_k[sel][idx]), 32'(exp_n));
      end
      if (w == HALT) begin
        halted = 1;
        break;
      end
      if (exp_n == mem) break;
    end
    check($sformatf("num_writes%0d", sel), 32'(obs_n[sel] - base_n[sel]), 32'(exp_n));
    check($sformatf("num_clears%0d", sel), 32'(clr_n[sel] - base_clr[sel]), 32'd1);
    check($sformatf("end_flags%0d", sel), flags(sel), (halted != 0) ? 32'b00010 : 32'b00001);
    check($sformatf("end_count%0d", sel), wcount(sel), 32'(exp_n));
    check($sformatf("end_instr%0d", sel), instr(sel), w);
  endtask

  task automatic finish_load();
    int k = 0;
    while ((bus64.o_busy || bus4.o_busy) && k < 60) begin
      tick();
      k++;
    end
    check("busy_timeout", 32'(k < 60), 32'd1);
    tick();
    tick();
    model_check(0, 64);
    model_check(1, 4);
  endtask

  task automatic program_load(input int n_words, input int max_gap);
    start_load();
    for (int i = 0; i < n_words; i++) send_word($urandom | 32'h8000_0000, max_gap);
    send_word(HALT, max_gap);
    finish_load();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bv    = 1'b0;
    bt    = 8'h00;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_flags%0d", s), flags(s), 32'd0);
      check($sformatf("reset_count%0d", s), wcount(s), 32'd0);
      check($sformatf("reset_instr%0d", s), instr(s), 32'd0);
    end

    // Known word then HALT.
    start_load();
    send_word(32'hDEAD_BEEF, 2);
    send_word(HALT, 2);
    finish_load();

    // Three words with long random gaps, HALT lands exactly on the 4-word memory limit.
    program_load(3, 20);

    // Five words then HALT: the 4-word memory overflows, the 64-word one finishes.
    program_load(5, 3);

    // Back-to-back bytes: every word's first byte arrives in the WRITE cycle.
    program_load(3, 0);

    // Reset after two bytes of a word aborts without any strobe.
    start_load();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      check($sformatf("abort_writes%0d", s), 32'(obs_n[s] - base_n[s]), 32'd0);
      check($sformatf("abort_flags%0d", s), flags(s), 32'd0);
      check($sformatf("abort_count%0d", s), wcount(s), 32'd0);
      check($sformatf("abort_instr%0d", s), instr(s), 32'd0);
    end
    start_load();
    send_word(32'hCAFE_F00D, 1);
    send_word(HALT, 1);
    finish_load();

    // Fill the 64-word memory with no HALT; a 65th word must be dropped.
    start_load();
    for (int i = 0; i < 65; i++) send_word($urandom | 32'h8000_0000, 1);
    finish_load();

    // Random program lengths.
    for (int r = 0; r < 4; r++) program_load(int'($urandom_range(6, 1)), 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
